// File: rtl/event_token_pkg.sv
// Shared types, default widths and the saturating step helper for the event token source.
package event_token_pkg;

    localparam int DEF_CNT_WIDTH  = 8;
    localparam int DEF_GAP_WIDTH  = 4;
    localparam int DEF_DROP_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ARMED   = ARMED;
    localparam logic [1:0] ST_HOLDOFF = HOLDOFF;

    // One step of an up/down counter that sticks at 0 and at all-ones (width <= 32).
    function automatic logic [31:0] sat_step(input logic [31:0] value,
                                             input logic        inc,
                                             input logic        dec,
                                             input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (inc && !dec)
            return (value >= max_val) ? max_val : value + 32'd1;
        if (dec && !inc)
            return (value == 32'd0) ? 32'd0 : value - 32'd1;
        return value;
    endfunction

endpackage

// File: rtl/event_token_source_sat_counter.sv
// Saturating up/down counter with synchronous clear; flags an increment lost at all-ones.
module sat_counter
    import event_token_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             ovf,
    output logic             unf
);

    always_comb begin
        count_next = clr ? '0 : WIDTH'(sat_step(32'(count), inc, dec, WIDTH));
        ovf        = !clr && inc && !dec && (&count);
        unf        = !clr && dec && !inc && (count == '0);
    end

    // NOTE: registers are updated with <= so every always_ff sees the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (!RST_N)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/event_token_source.sv
// Turns event pulses into a backlog of tokens and drains them one per handshake with a minimum gap.
module event_token_source
    import event_token_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int GAP_WIDTH  = DEF_GAP_WIDTH,
    parameter int DROP_WIDTH = DEF_DROP_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EVT,
    input  logic [GAP_WIDTH-1:0]  GAP,
    input  logic                  CLR,
    input  logic                  FULL_N,
    output logic                  ENQ,
    output logic [CNT_WIDTH-1:0]  PENDING,
    output logic                  OVF,
    output logic [DROP_WIDTH-1:0] DROPS
);

    localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [GAP_WIDTH-1:0]  gap_d;
    logic                  ovf_q;
    logic [CNT_WIDTH-1:0]  pend_next;
    logic                  pend_ovf;
    logic                  pend_unf;
    logic [DROP_WIDTH-1:0] drops_next_unused;
    logic                  drops_ovf_unused;
    logic                  drops_unf_unused;

    // ENQ depends only on registered state and FULL_N; EVT never reaches it.
    assign ENQ = RST_N && !CLR && FULL_N && (state_q == ST_ARMED);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_pending (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clr        (CLR),
        .inc        (EVT),
        .dec        (ENQ),
        .count      (PENDING),
        .count_next (pend_next),
        .ovf        (pend_ovf),
        .unf        (pend_unf)
    );

    sat_counter #(.WIDTH(DROP_WIDTH)) u_drops (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clr        (CLR),
        .inc        (pend_ovf),
        .dec        (1'b0),
        .count      (DROPS),
        .count_next (drops_next_unused),
        .ovf        (drops_ovf_unused),
        .unf        (drops_unf_unused)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_next != '0)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (ENQ) begin
                    if (GAP != '0) begin
                        state_d = ST_HOLDOFF;
                        gap_d   = GAP;
                    end else if (pend_next == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLDOFF: begin
                gap_d = gap_q - GAP_ONE;
                if (gap_q == GAP_ONE)
                    state_d = (pend_next != '0) ? ST_ARMED : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gap_d   = '0;
            end
        endcase
    end

    // NOTE: reset is synchronous; RST_N is only looked at on the clock edge, sharing the CLR path.
    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            if (pend_ovf)
                ovf_q <= 1'b1;
        end
    end

    assign OVF = ovf_q;

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert (!(ENQ && !FULL_N))
                else $warning("event_token_source: enqueue while downstream full");
            assert (!pend_unf)
                else $warning("event_token_source: pending count underflow");
        end
    end

endmodule

// File: tb/tb_event_token_source.sv
// Self-checking bench: directed vector table, hand sequences, then randomized run against a model.
module tb_event_token_source;

    localparam int CW   = 4;
    localparam int GW   = 4;
    localparam int DW   = 16;
    localparam int MAXP = (1 << CW) - 1;
    localparam int MAXD = (1 << DW) - 1;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          EVT;
    logic [GW-1:0] GAP;
    logic          CLR;
    logic          FULL_N;
    logic          ENQ;
    logic [CW-1:0] PENDING;
    logic          OVF;
    logic [DW-1:0] DROPS;

    event_token_source #(.CNT_WIDTH(CW), .GAP_WIDTH(GW), .DROP_WIDTH(DW)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .EVT     (EVT),
        .GAP     (GAP),
        .CLR     (CLR),
        .FULL_N  (FULL_N),
        .ENQ     (ENQ),
        .PENDING (PENDING),
        .OVF     (OVF),
        .DROPS   (DROPS)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: a backlog count, a remaining-gap count and drop bookkeeping.
    int m_pend, m_gap, m_drops;
    bit m_ovf, m_enq, model_valid;
    bit use_fifo, fifo_full, deq;
    int evt_count, enq_count;

    typedef struct {
        bit          rst_n, evt, clr, full_n;
        int          gap;
        bit          enq;
        int          pend;
        bit          ovf;
        int          drops;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t vec(bit r, bit e, bit c, bit f, int g, bit q, int p, bit o, int d);
        vec_t v;
        v.rst_n = r; v.evt = e; v.clr = c; v.full_n = f; v.gap = g;
        v.enq = q; v.pend = p; v.ovf = o; v.drops = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit c, input bit f, input int g);
        RST_N = r; EVT = e; CLR = c; FULL_N = f; GAP = GW'(g);
    endtask

    // Sample at the falling edge and compare against the model's view of the current cycle.
    task automatic cycle_begin();
        @(negedge CLK);
        if (model_valid) begin
            m_enq = RST_N && !CLR && FULL_N && (m_pend > 0) && (m_gap == 0);
            check("model_enq", 32'(ENQ), 32'(m_enq));
            check("model_pending", 32'(PENDING), 32'(m_pend));
            check("model_ovf", 32'(OVF), 32'(m_ovf));
            check("model_drops", 32'(DROPS), 32'(m_drops));
            check("enq_while_full", 32'(ENQ && !FULL_N), 32'd0);
        end
    endtask

    task automatic cycle_end();
        if (!RST_N || CLR) begin
            m_pend = 0; m_gap = 0; m_ovf = 0; m_drops = 0;
        end else begin
            if (EVT && !m_enq) begin
                if (m_pend == MAXP) begin
                    m_ovf = 1;
                    if (m_drops < MAXD) m_drops++;
                end else begin
                    m_pend++;
                end
            end else if (!EVT && m_enq) begin
                m_pend--;
            end
            if (m_enq) m_gap = int'(GAP);
            else if (m_gap > 0) m_gap--;
        end
        if (use_fifo) begin
            if (EVT) evt_count++;
            if (ENQ) enq_count++;
            if (fifo_full && deq) fifo_full = 0;
            else if (ENQ) fifo_full = 1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            cycle_end();
        end
    endtask

    initial begin
        model_valid = 0; use_fifo = 0; fifo_full = 0; deq = 0;
        evt_count = 0; enq_count = 0;
        drive(0, 0, 0, 1, 0);
        repeat (2) @(posedge CLK);
        #1;
        m_pend = 0; m_gap = 0; m_ovf = 0; m_drops = 0;
        model_valid = 1;

        // rst, evt, clr, full_n, gap | enq, pending, ovf, drops
        repeat (3) vecs.push_back(vec(0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vec(1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vec(1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vec(1, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(vec(1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vec(1, 1, 0, 1, 4, 0, 0, 0, 0));
        vecs.push_back(vec(1, 1, 0, 1, 4, 1, 1, 0, 0));
        vecs.push_back(vec(1, 1, 0, 1, 4, 0, 1, 0, 0));
        repeat (3) vecs.push_back(vec(1, 0, 0, 1, 4, 0, 2, 0, 0));
        vecs.push_back(vec(1, 0, 0, 1, 4, 1, 2, 0, 0));
        repeat (4) vecs.push_back(vec(1, 0, 0, 1, 4, 0, 1, 0, 0));
        vecs.push_back(vec(1, 0, 0, 1, 4, 1, 1, 0, 0));
        repeat (5) vecs.push_back(vec(1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vec(1, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) vecs.push_back(vec(1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(vec(1, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(vec(1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vec(1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(vec(1, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(vec(1, 0, 0, 1, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].evt, vecs[i].clr, vecs[i].full_n, vecs[i].gap);
            cycle_begin();
            check($sformatf("vec%0d_enq", i), 32'(ENQ), 32'(vecs[i].enq));
            check($sformatf("vec%0d_pending", i), 32'(PENDING), 32'(vecs[i].pend));
            check($sformatf("vec%0d_ovf", i), 32'(OVF), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_drops", i), 32'(DROPS), 32'(vecs[i].drops));
            cycle_end();
        end

        // Backpressure until saturation, then simultaneous EVT/ENQ at the ceiling.
        drive(1, 1, 0, 0, 0);
        run(20);
        drive(1, 1, 0, 1, 0);
        cycle_begin();
        check("sat_pending", 32'(PENDING), 32'd15);
        check("sat_ovf", 32'(OVF), 32'd1);
        check("sat_drops", 32'(DROPS), 32'd5);
        cycle_end();
        for (int i = 0; i < 9; i++) begin
            cycle_begin();
            check("simul_enq", 32'(ENQ), 32'd1);
            cycle_end();
        end
        drive(1, 0, 0, 1, 0);
        cycle_begin();
        check("simul_pending", 32'(PENDING), 32'd15);
        check("simul_drops", 32'(DROPS), 32'd5);
        cycle_end();
        run(7);

        // Clear in the middle of a holdoff with a backlog of 7.
        drive(1, 1, 0, 1, 5);
        cycle_begin();
        check("pre_clr_enq", 32'(ENQ), 32'd1);
        check("pre_clr_pending", 32'(PENDING), 32'd7);
        cycle_end();
        drive(1, 1, 1, 1, 0);
        cycle_begin();
        check("clr_cycle_enq", 32'(ENQ), 32'd0);
        check("clr_cycle_pending", 32'(PENDING), 32'd7);
        check("clr_cycle_ovf", 32'(OVF), 32'd1);
        cycle_end();
        drive(1, 0, 0, 1, 0);
        cycle_begin();
        check("post_clr_pending", 32'(PENDING), 32'd0);
        check("post_clr_ovf", 32'(OVF), 32'd0);
        check("post_clr_drops", 32'(DROPS), 32'd0);
        check("post_clr_enq", 32'(ENQ), 32'd0);
        cycle_end();

        // Reset with a backlog waiting in ARMED.
        drive(1, 1, 0, 0, 0);
        run(3);
        drive(0, 1, 0, 1, 0);
        cycle_begin();
        check("rst_backlog_enq", 32'(ENQ), 32'd0);
        check("rst_backlog_pending", 32'(PENDING), 32'd3);
        cycle_end();
        drive(1, 0, 0, 1, 0);
        cycle_begin();
        check("post_rst_pending", 32'(PENDING), 32'd0);
        check("post_rst_enq", 32'(ENQ), 32'd0);
        cycle_end();

        // Randomized traffic into a depth-1 downstream FIFO.
        use_fifo = 1;
        fifo_full = 0;
        evt_count = 0;
        enq_count = 0;
        for (int i = 0; i < 10000; i++) begin
            deq = ($urandom_range(99) < 50);
            drive(1, $urandom_range(99) < 30, 0, !fifo_full, $urandom_range(3));
            cycle_begin();
            cycle_end();
        end
        use_fifo = 0;
        check("token_conservation", 32'(enq_count), 32'(evt_count - m_drops - m_pend));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_token_source.md
# event_token_source

Upstream producer for the depth-1 zero-data token FIFO (ENQ/FULL_N side). It accumulates single-cycle event pulses into a saturating pending-token count and drains them one token per handshake into the downstream FIFO. It enforces a programmable minimum spacing between emitted tokens. Overflow is flagged sticky and dropped events are counted, so control software can detect lost events.

## Interface
Parameters:
- CNT_WIDTH, 8: width of pending-token counter; saturates at 2^CNT_WIDTH-1.
- GAP_WIDTH, 4: width of holdoff gap value/counter.
- DROP_WIDTH, 8: width of dropped-event counter; saturates at all-ones.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  reset; one clock; reset is synchronous and active-low.
- EVT  in  1  event pulse; one token requested per cycle high.
- GAP  in  GAP_WIDTH  minimum idle cycles after each ENQ; sampled at the ENQ cycle.
- CLR  in  1  synchronous clear of all state; priority over EVT/ENQ.
- FULL_N  in  1  downstream FIFO not full.
- ENQ  out  1  token enqueue to downstream; asserted only when FULL_N=1.
- PENDING  out  CNT_WIDTH  registered pending-token count.
- OVF  out  1  sticky: an event was dropped at saturation.
- DROPS  out  DROP_WIDTH  saturating count of dropped events.

## Operation
- States (registered): IDLE (pending=0, gap=0), ARMED (pending>0, gap=0), HOLDOFF (gap>0).
- ENQ = (state==ARMED) && FULL_N && !CLR. ENQ is combinational from the registered state and FULL_N only. There is no path from EVT to ENQ.
- Pending update per cycle, with inc = EVT and dec = ENQ:
  - inc && !dec && pending==max: pending holds, OVF<=1, DROPS+1 (saturating).
  - inc && !dec otherwise: pending+1.
  - !inc && dec: pending-1.
  - inc && dec: pending unchanged, and no drop even at max.
- Gap counter:
  - On ENQ, load GAP. If GAP=0, the next state is ARMED or IDLE directly.
  - In HOLDOFF, decrement by 1 per cycle. EVT is still accepted into pending.
- Transitions:
  - IDLE→ARMED on EVT.
  - ARMED→HOLDOFF on ENQ when GAP≠0.
  - ARMED→IDLE on ENQ when GAP=0 and the post-update pending is 0.
  - HOLDOFF→ARMED/IDLE when the counter reaches 0 (choice by pending).
  - ARMED holds while FULL_N=0.
- CLR: next cycle pending=0, gap=0, OVF=0, DROPS=0, state IDLE. ENQ=0 in the CLR cycle and an EVT in that cycle is discarded (not counted as a drop).
- Reset (RST_N=0 at posedge): same values as CLR. ENQ=0 while RST_N=0. Reset mid-holdoff or mid-backlog discards all tokens.
- Sim-only checks: warn if ENQ && !FULL_N, and if pending underflow would occur.

## Timing
- EVT at cycle n → PENDING and state visible n+1 → earliest ENQ n+1 (latency 1).
- ENQ at cycle n with GAP=g → next ENQ no earlier than n+g+1. With g=0, back-to-back ENQ is allowed if FULL_N stays high.
- With a depth-1 downstream FIFO, FULL_N is low after each ENQ until DEQ. Throughput is bounded by the downstream, not by this block.
- OVF and DROPS update one cycle after the dropping EVT.
- All outputs except ENQ are registered. ENQ has one combinational level from FULL_N.

## Structure
- Shared package event_token_pkg:
  - State enum (IDLE=2'd0, ARMED=2'd1, HOLDOFF=2'd2).
  - Default widths.
  - Helper function for saturating increment.
- One natural sub-module: sat_counter (parameterized width, inc/dec/clr, saturating at all-ones, flags overflow). Instantiate it for pending; DROPS uses inc-only mode.
- Expected RTL: ~180 lines including sim checks.

## Test plan
- Reset: hold RST_N=0 3 cycles with EVT=1, FULL_N=1 → ENQ=0 throughout, then PENDING=0, OVF=0, DROPS=0, state IDLE.
- Single token: EVT at cycle 10, GAP=0, FULL_N=1 → ENQ=1 at cycle 11 only, PENDING 1 at 11, 0 at 12.
- Gap: 3 EVT pulses at cycles 0-2, GAP=4, FULL_N=1 → ENQ at cycles 1, 6, 11.
- Backpressure and simultaneity: FULL_N=0 for 20 cycles with EVT every cycle, CNT_WIDTH=4 → PENDING saturates at 15, OVF=1, DROPS=5. Then FULL_N=1 with EVT=1 and GAP=0 → PENDING holds at 15 and no further drops.
- Clear: CLR=1 while PENDING=7 in HOLDOFF with EVT=1 → next cycle PENDING=0, OVF=0, DROPS=0, IDLE, ENQ=0 in the CLR cycle.
- Integration with the downstream FIFO: random DEQ (50%) and EVT (30%) over 10k cycles, GAP random 0-3 → total ENQ count = EVT count − DROPS − final PENDING, and no enqueue-to-full warnings.
